// File: rtl/writeback_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_pipe_if
// Purpose  : Result-side bundle of the dual-issue fetch/forwarding interface:
//            comb result packets and flush in; stage buses, register file and
//            retire counter out.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_pipe_if #(
    parameter int CNT_W = 32
);
    logic [149:0]          regStg_evencomb;
    logic [149:0]          regStg_oddcomb;
    logic                  flush;

    logic [149:0]          regStg_1e, regStg_2e, regStg_3e, regStg_4e;
    logic [149:0]          regStg_5e, regStg_6e, regStg_7e, regStg_8e;
    logic [149:0]          regStg_1o, regStg_2o, regStg_3o, regStg_4o;
    logic [149:0]          regStg_5o, regStg_6o, regStg_7o, regStg_8o;

    logic [127:0][127:0]   reg_file;
    logic [CNT_W-1:0]      retire_count;

    modport master (
        output regStg_evencomb, regStg_oddcomb, flush,
        input  regStg_1e, regStg_2e, regStg_3e, regStg_4e,
        input  regStg_5e, regStg_6e, regStg_7e, regStg_8e,
        input  regStg_1o, regStg_2o, regStg_3o, regStg_4o,
        input  regStg_5o, regStg_6o, regStg_7o, regStg_8o,
        input  reg_file, retire_count
    );

    modport slave (
        input  regStg_evencomb, regStg_oddcomb, flush,
        output regStg_1e, regStg_2e, regStg_3e, regStg_4e,
        output regStg_5e, regStg_6e, regStg_7e, regStg_8e,
        output regStg_1o, regStg_2o, regStg_3o, regStg_4o,
        output regStg_5o, regStg_6o, regStg_7o, regStg_8o,
        output reg_file, retire_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module   : writeback_pipe
// Purpose  : 8-stage even/odd result pipeline with forwarding taps, branch
//            flush of the two youngest stages, register-file commit from stage
//            8 and a saturating retired-write counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_pipe #(
    parameter int NSTG  = 8,
    parameter int CNT_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    writeback_pipe_if.slave   wb
);

    localparam int c_PKT_W  = 150;
    localparam int c_VLD    = 149;
    localparam int c_RT_HI  = 134;
    localparam int c_RT_LO  = 128;
    localparam int c_DATA_W = 128;
    localparam int c_NREG   = 128;
    localparam int c_NPIPE  = 2;

    typedef logic [c_PKT_W-1:0] pkt_t;

    pkt_t                               w_in    [c_NPIPE];
    pkt_t                               r_stg   [c_NPIPE][NSTG];
    logic [c_NREG-1:0][c_DATA_W-1:0]    r_reg_file;
    logic [CNT_W-1:0]                   r_retire_count;

    logic                               w_we_e;
    logic                               w_we_o;
    logic [6:0]                         w_rt_e;
    logic [6:0]                         w_rt_o;
    logic [c_DATA_W-1:0]                w_data_e;
    logic [c_DATA_W-1:0]                w_data_o;
    logic [1:0]                         w_commits;
    logic [CNT_W:0]                     w_cnt_sum;
    logic [CNT_W-1:0]                   w_cnt_next;

    assign w_in[0] = wb.regStg_evencomb;
    assign w_in[1] = wb.regStg_oddcomb;

    // Flush clears only the valid bit of the two youngest stages; payload keeps moving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < c_NPIPE; p++) begin
                for (int k = 0; k < NSTG; k++) begin
                    r_stg[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < c_NPIPE; p++) begin
                r_stg[p][0] <= {w_in[p][c_VLD] & ~wb.flush, w_in[p][c_VLD-1:0]};
                r_stg[p][1] <= {r_stg[p][0][c_VLD] & ~wb.flush, r_stg[p][0][c_VLD-1:0]};
                for (int k = 2; k < NSTG; k++) begin
                    r_stg[p][k] <= r_stg[p][k-1];
                end
            end
        end
    end

    assign w_we_e   = r_stg[0][NSTG-1][c_VLD];
    assign w_we_o   = r_stg[1][NSTG-1][c_VLD];
    assign w_rt_e   = r_stg[0][NSTG-1][c_RT_HI:c_RT_LO];
    assign w_rt_o   = r_stg[1][NSTG-1][c_RT_HI:c_RT_LO];
    assign w_data_e = r_stg[0][NSTG-1][c_DATA_W-1:0];
    assign w_data_o = r_stg[1][NSTG-1][c_DATA_W-1:0];

    // Odd write is issued last so it wins a same-address pair (odd is younger).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_file <= '0;
        end else begin
            if (w_we_e) begin
                r_reg_file[w_rt_e] <= w_data_e;
            end
            if (w_we_o) begin
                r_reg_file[w_rt_o] <= w_data_o;
            end
        end
    end

    assign w_commits  = {1'b0, w_we_e} + {1'b0, w_we_o};
    assign w_cnt_sum  = {1'b0, r_retire_count} + {{(CNT_W-1){1'b0}}, w_commits};
    assign w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else begin
            r_retire_count <= w_cnt_next;
        end
    end

    assign wb.regStg_1e = r_stg[0][0];
    assign wb.regStg_2e = r_stg[0][1];
    assign wb.regStg_3e = r_stg[0][2];
    assign wb.regStg_4e = r_stg[0][3];
    assign wb.regStg_5e = r_stg[0][4];
    assign wb.regStg_6e = r_stg[0][5];
    assign wb.regStg_7e = r_stg[0][6];
    assign wb.regStg_8e = r_stg[0][7];

    assign wb.regStg_1o = r_stg[1][0];
    assign wb.regStg_2o = r_stg[1][1];
    assign wb.regStg_3o = r_stg[1][2];
    assign wb.regStg_4o = r_stg[1][3];
    assign wb.regStg_5o = r_stg[1][4];
    assign wb.regStg_6o = r_stg[1][5];
    assign wb.regStg_7o = r_stg[1][6];
    assign wb.regStg_8o = r_stg[1][7];

    assign wb.reg_file     = r_reg_file;
    assign wb.retire_count = r_retire_count;

endmodule
`default_nettype wire
